// File: rtl/pipe_pkg.sv
// pipe_pkg: stage-boundary payload bundles, widths and occupancy codes shared by the pipeline registers.
package pipe_pkg;
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] pc_plus4;
      logic [31:0] instruction;
   } ifid_t;
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] pc_plus4;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] imm;
      logic [4:0]  rd;
      logic        reg_write;
      logic [1:0]  result_src;
      logic        mem_write;
      logic [2:0]  alu_ctrl;
      logic        alu_src;
      logic        branch;
      logic        jump;
   } idex_t;
   typedef struct packed {
      logic [31:0] alu_result;
      logic [31:0] write_data;
      logic [31:0] pc_plus4;
      logic [31:0] instruction;
      logic [4:0]  rd;
      logic        reg_write;
      logic [1:0]  result_src;
      logic        mem_write;
   } exmem_t;
   typedef struct packed {
      logic [31:0] alu_result;
      logic [31:0] r_data;
      logic [31:0] pc_plus4;
      logic [31:0] instruction;
      logic [4:0]  rd;
      logic        reg_write;
      logic [1:0]  result_src;
   } memwb_t;
   localparam int IFID_W  = $bits(ifid_t);
   localparam int IDEX_W  = $bits(idex_t);
   localparam int EXMEM_W = $bits(exmem_t);
   localparam int MEMWB_W = $bits(memwb_t);
   localparam logic [1:0] OCC_EMPTY = 2'd0;
   localparam logic [1:0] OCC_ONE   = 2'd1;
   localparam logic [1:0] OCC_TWO   = 2'd2;
endpackage

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: generic valid/ready pipeline register with flush and optional two-entry skid buffer.
module pipe_stage_skid
   import pipe_pkg::*;
#(
   parameter int DATA_W = MEMWB_W,
   parameter bit SKID   = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy
);
   logic [DATA_W-1:0] main_q, main_d;
   logic [1:0]        occ_q, occ_d;
   logic              acc, drain;
   assign out_valid = occ_q != OCC_EMPTY;
   assign out_data  = main_q;
   assign occupancy = occ_q;
   assign acc       = in_valid & in_ready & ~flush;
   assign drain     = out_valid & out_ready;
   // occupancy is the entry count, so it moves by accept minus drain
   always_comb occ_d = flush ? OCC_EMPTY : occ_q + {1'b0, acc} - {1'b0, drain};
   always_ff @(posedge clk) begin
      if (reset) begin
         occ_q  <= OCC_EMPTY;
         main_q <= '0;
      end else begin
         occ_q  <= occ_d;
         main_q <= main_d;
      end
   end
   generate
      if (SKID) begin : g_skid
         logic [DATA_W-1:0] skid_q, skid_d;
         assign in_ready = occ_q != OCC_TWO;
         // main always holds the oldest entry; empty slots are kept zero so bubbles are all-zero
         always_comb begin
            main_d = flush ? '0
                   : (occ_q == OCC_TWO) ? (drain ? skid_q : main_q)
                   : (drain | (occ_q == OCC_EMPTY)) ? (acc ? in_data : '0)
                   : main_q;
            skid_d = flush ? '0
                   : ((occ_q == OCC_TWO) & drain) ? '0
                   : ((occ_q == OCC_ONE) & acc & ~drain) ? in_data
                   : skid_q;
         end
         always_ff @(posedge clk) begin
            if (reset) skid_q <= '0;
            else       skid_q <= skid_d;
         end
      end else begin : g_reg
         assign in_ready = (occ_q == OCC_EMPTY) | out_ready;
         always_comb main_d = flush ? '0 : acc ? in_data : drain ? '0 : main_q;
      end
   endgenerate
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: scoreboard bench for the skid (SKID=1) and plain register (SKID=0) variants.
module tb_pipe_stage_skid;
   import pipe_pkg::*;
   localparam int W = MEMWB_W;
   logic clk, reset;
   logic flush_s, iv_s, ir_s, ov_s, or_s;
   logic flush_r, iv_r, ir_r, ov_r, or_r;
   logic [W-1:0] id_s, od_s, id_r, od_r;
   logic [1:0] occ_s, occ_r;
   logic [W-1:0] q_s[$], q_r[$];
   int checks = 0, failures = 0;
   memwb_t pkt_a, pkt_b, seen;

   pipe_stage_skid #(.DATA_W(W), .SKID(1'b1)) u_skid (
      .clk(clk), .reset(reset), .flush(flush_s), .in_valid(iv_s), .in_ready(ir_s), .in_data(id_s),
      .out_valid(ov_s), .out_ready(or_s), .out_data(od_s), .occupancy(occ_s));
   pipe_stage_skid #(.DATA_W(W), .SKID(1'b0)) u_reg (
      .clk(clk), .reset(reset), .flush(flush_r), .in_valid(iv_r), .in_ready(ir_r), .in_data(id_r),
      .out_valid(ov_r), .out_ready(or_r), .out_data(od_r), .occupancy(occ_r));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (reset) q_s.delete();
      else begin
         chk("s_occ", occ_s, q_s.size());
         chk("s_out_valid", ov_s, q_s.size() != 0);
         chk("s_in_ready", ir_s, q_s.size() != 2);
         if (!ov_s) chk("s_bubble_zero", od_s, 0);
         if (ov_s && or_s) begin
            if (q_s.size() == 0) chk("s_underflow", 1, 0);
            else chk("s_data", od_s, q_s.pop_front());
         end
         if (flush_s) q_s.delete();
         else if (iv_s && ir_s) q_s.push_back(id_s);
      end
   end

   always @(negedge clk) begin
      if (reset) q_r.delete();
      else begin
         chk("r_occ", occ_r, q_r.size());
         chk("r_out_valid", ov_r, q_r.size() != 0);
         chk("r_in_ready", ir_r, (q_r.size() == 0) || or_r);
         if (!ov_r) chk("r_bubble_zero", od_r, 0);
         if (ov_r && or_r) begin
            if (q_r.size() == 0) chk("r_underflow", 1, 0);
            else chk("r_data", od_r, q_r.pop_front());
         end
         if (flush_r) q_r.delete();
         else if (iv_r && ir_r) q_r.push_back(id_r);
      end
   end

   initial begin
      reset = 1'b1;
      {flush_s, iv_s, or_s, flush_r, iv_r, or_r} = '0;
      id_s = '0;
      id_r = '0;
      repeat (2) tick();
      reset = 1'b0;
      // reset mid-stream
      iv_s = 1'b1; id_s = W'(8'hA5);
      tick();
      iv_s = 1'b0;
      chk("t1_loaded", od_s, W'(8'hA5));
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("t1_ov", ov_s, 0);
      chk("t1_od", od_s, 0);
      chk("t1_occ", occ_s, 0);
      chk("t1_ir", ir_s, 1);
      // streaming
      or_s = 1'b1; iv_s = 1'b1; id_s = W'(1);
      tick(); id_s = W'(2);
      chk("t2_out1", od_s, W'(1)); chk("t2_occ1", occ_s, 1);
      tick(); id_s = W'(3);
      chk("t2_out2", od_s, W'(2)); chk("t2_occ2", occ_s, 1);
      tick(); iv_s = 1'b0;
      chk("t2_out3", od_s, W'(3)); chk("t2_ir", ir_s, 1);
      tick();
      chk("t2_empty", ov_s, 0);
      // backpressure
      or_s = 1'b0; iv_s = 1'b1; id_s = W'(8'h10);
      tick(); id_s = W'(8'h11);
      tick(); id_s = W'(8'h12);
      chk("t3_occ2", occ_s, 2); chk("t3_ir0", ir_s, 0); chk("t3_hold", od_s, W'(8'h10));
      repeat (2) tick();
      chk("t3_still_hold", od_s, W'(8'h10)); chk("t3_still_occ2", occ_s, 2);
      or_s = 1'b1;
      tick();
      chk("t3_out11", od_s, W'(8'h11));
      tick(); iv_s = 1'b0;
      chk("t3_out12", od_s, W'(8'h12));
      tick();
      chk("t3_drained", ov_s, 0);
      // flush in TWO, then flush in ONE with a live downstream transfer
      or_s = 1'b0; iv_s = 1'b1; id_s = W'(8'h1E);
      tick(); id_s = W'(8'h1F);
      tick(); id_s = W'(8'h20); flush_s = 1'b1;
      tick(); flush_s = 1'b0; iv_s = 1'b0;
      chk("t4_occ", occ_s, 0); chk("t4_ov", ov_s, 0); chk("t4_od", od_s, 0); chk("t4_ir", ir_s, 1);
      or_s = 1'b1;
      repeat (2) tick();
      iv_s = 1'b1; id_s = W'(8'h21);
      tick(); id_s = W'(8'h22); flush_s = 1'b1;
      tick(); flush_s = 1'b0; iv_s = 1'b0;
      chk("t4b_occ", occ_s, 0);
      // SKID=0 stall
      or_r = 1'b0; iv_r = 1'b1; id_r = W'(8'h2F);
      tick(); iv_r = 1'b0;
      #1 chk("t5_stall_ir", ir_r, 0);
      or_r = 1'b1; iv_r = 1'b1; id_r = W'(8'h30);
      #1 chk("t5_release_ir", ir_r, 1);
      tick(); iv_r = 1'b0;
      chk("t5_out30", od_r, W'(8'h30));
      tick();
      chk("t5_empty_od", od_r, 0);
      // MEM/WB bundle, earlier beat kept, later beat flushed
      pkt_a = '{alu_result: 32'hDEADBEEF, r_data: 32'hCAFEF00D, pc_plus4: 32'h104,
                instruction: 32'h00500293, rd: 5'd5, reg_write: 1'b1, result_src: 2'd0};
      pkt_b = pkt_a;
      pkt_b.rd = 5'd6;
      or_s = 1'b1; iv_s = 1'b1; id_s = pkt_a;
      tick(); id_s = pkt_b; flush_s = 1'b1;
      chk("t6_beat_a", od_s, pkt_a);
      tick(); flush_s = 1'b0; iv_s = 1'b0;
      seen = memwb_t'(od_s);
      chk("t6_bubble_regwrite", seen.reg_write, 0);
      chk("t6_bubble_rd", seen.rd, 0);
      // random traffic with occasional flush on both variants
      for (int i = 0; i < 400; i++) begin
         iv_s = 1'($urandom_range(0, 1)); or_s = 1'($urandom_range(0, 1));
         flush_s = ($urandom_range(0, 31) == 0);
         id_s = {$urandom(), $urandom(), $urandom(), $urandom(), 8'($urandom())};
         iv_r = 1'($urandom_range(0, 1)); or_r = 1'($urandom_range(0, 1));
         flush_r = ($urandom_range(0, 31) == 0);
         id_r = {$urandom(), $urandom(), $urandom(), $urandom(), 8'($urandom())};
         tick();
      end
      {flush_s, iv_s, flush_r, iv_r} = '0;
      or_s = 1'b1; or_r = 1'b1;
      repeat (4) tick();
      chk("end_s_queue", q_s.size(), 0);
      chk("end_r_queue", q_r.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
Parametrised successor to the fixed MEM/WB register: one generic valid/ready pipeline stage that carries a packed payload between any two processor stages. It adds backpressure (stall), synchronous flush (bubble insertion) and an optional two-entry skid buffer, so that ready is registered and timing paths are cut. The core instantiates it between IF/ID, ID/EX, EX/MEM and MEM/WB, with the payload packed from each stage's fields.

Parameters:
- DATA_W, 136: payload width. The default is the MEM/WB bundle: ALUResult 32 + readData 32 + PC+4 32 + instruction 32 + rd 5 + regWrite 1 + resultSrc 2.
- SKID, 1: 1 selects a two-entry skid buffer with registered in_ready; 0 selects a single register with combinational in_ready.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- flush  in  1  synchronous; discard all held entries, insert bubble
- in_valid  in  1  upstream has payload
- in_ready  out  1  stage can accept this cycle
- in_data  in  DATA_W  upstream payload
- out_valid  out  1  payload presented downstream
- out_ready  in  1  downstream accepts this cycle
- out_data  out  DATA_W  payload to downstream; all-zero when out_valid=0
- occupancy  out  2  entries held (0..2; max 1 when SKID=0)

Behaviour:
- Clock and reset: clock clk; reset reset, synchronous, active-high.
- Reset values: out_valid=0, out_data=0, occupancy=0, skid entry cleared. in_ready=1 from the first cycle after reset; with SKID=0, in_ready follows its combinational equation.
- Handshakes:
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
  - Latency is 1 cycle: data accepted at edge N appears on out_data after edge N when the stage was empty.
- Stability: while out_valid=1 and out_ready=0, out_data and out_valid hold unchanged, and no entry is lost or reordered. Order is strict FIFO.
- SKID=1 state machine, registered, with occupancy encoding the state:
  - EMPTY (0): in_ready=1, out_valid=0.
    - accept → ONE.
  - ONE (1): in_ready=1, out_valid=1, main register holds the entry.
    - accept & !drain → TWO (the new entry goes to skid).
    - accept & drain → ONE (the new entry goes to main).
    - !accept & drain → EMPTY.
    - otherwise hold.
  - TWO (2): in_ready=0, out_valid=1.
    - drain → ONE (skid moves to main, skid zeroed).
    - otherwise hold.
  - Accept in TWO is impossible; in_valid is ignored there.
- SKID=0:
  - in_ready = !out_valid | out_ready (combinational).
  - accept loads main; drain without accept clears out_valid and zeroes out_data.
- Zero bubble: a drain to empty zeroes out_data. A bubble therefore carries regWrite=0 and the instruction field decodes as an illegal instruction, never a valid write.
- Flush:
  - On the next edge: occupancy=0, out_valid=0, out_data=0, skid cleared.
  - Any input presented in the flush cycle is dropped, even if in_valid & in_ready.
  - A downstream transfer in the flush cycle still counts as completed (downstream saw it).
- Priority: reset > flush > normal operation.
- Reset or flush mid-stall (state TWO) discards both entries; in_ready is 1 again on the following cycle.
- Simultaneous accept and drain in ONE keeps full throughput: one transfer per cycle, no bubble.
- Payload content is not interpreted; any bit pattern passes unmodified.

Decomposition:
- Shared package pipe_pkg:
  - DATA_W constants per stage boundary (IFID_W, IDEX_W, EXMEM_W, MEMWB_W).
  - Packed struct typedefs for each stage bundle, including memwb_t {alu_result, r_data, pc_plus4, instruction, rd, reg_write, result_src}.
  - Occupancy localparams OCC_EMPTY=0, OCC_ONE=1, OCC_TWO=2.
- No sub-module needed. The main and skid registers plus the state logic stay in one module; SKID is resolved by a generate branch.

Test Plan:
1. Reset mid-stream: load 0xA5 payload, assert reset one cycle → out_valid=0, out_data=0, occupancy=0; in_ready=1 the next cycle.
2. Streaming, SKID=1, out_ready=1: send 0x1, 0x2, 0x3 on consecutive cycles → outputs 0x1, 0x2, 0x3 on consecutive cycles, each 1 cycle after input; occupancy stays 1; in_ready never drops.
3. Backpressure: out_ready=0, send 0x10 then 0x11 → occupancy=2, in_ready=0, out_data holds 0x10. A third input 0x12 held by upstream is not accepted. Release out_ready → 0x10, 0x11, 0x12 emerge in order.
4. Flush in TWO with in_valid=1, in_data=0x20 → next cycle occupancy=0, out_valid=0, out_data=0; 0x20 never appears downstream.
5. SKID=0 stall: out_valid=1, out_ready=0 → in_ready=0 in the same cycle. Raise out_ready with in_valid=1, data 0x30 → in_ready=1 in the same cycle; 0x30 appears on out_data the next cycle.
6. MEM/WB bundle: pack regWrite=1, rd=5, ALUResult=0xDEADBEEF, send, then flush → bubble cycle shows regWrite=0 and rd=0; the unflushed earlier beat arrives bit-exact.
